// File: rtl/bcd_scan_display_pkg.sv
// Shared seven-segment constants and payload types for the multiplexed BCD display.
package bcd_scan_display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned DIGITS_W   = NUM_DIGITS * BCD_W;
    localparam int unsigned SEG_W      = 7;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic                  dp;
        logic [SEG_W-1:0]      seg;
    } disp_out_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
    import bcd_scan_display_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [SEG_W-1:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg_c = SEG_0;
            4'd1:    o_seg_c = SEG_1;
            4'd2:    o_seg_c = SEG_2;
            4'd3:    o_seg_c = SEG_3;
            4'd4:    o_seg_c = SEG_4;
            4'd5:    o_seg_c = SEG_5;
            4'd6:    o_seg_c = SEG_6;
            4'd7:    o_seg_c = SEG_7;
            4'd8:    o_seg_c = SEG_8;
            4'd9:    o_seg_c = SEG_9;
            default: o_seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed BCD display driver with per-frame snapshot, leading-zero
// blanking and per-digit blink.
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS_W-1:0]   digits,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] blink_en,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam disp_out_t   OUT_RESET = '{an: '1, dp: 1'b1, seg: SEG_BLANK};

    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_idx;
    logic [DIGITS_W-1:0]   r_snap;
    logic [NUM_DIGITS-1:0] r_dp_snap;
    logic [BLK_W-1:0]      r_blk_cnt;
    logic                  r_blink_phase;
    logic                  r_frame;
    disp_out_t             r_out;

    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_blink_wrap;
    logic [BCD_W-1:0]      w_nibble;
    logic [SEG_W-1:0]      w_seg_dec;
    logic [NUM_DIGITS-1:0] w_lz_blank;
    logic                  w_blank;
    disp_out_t             w_out;

    assign w_tick       = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_wrap       = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_blink_wrap = w_wrap && (r_blk_cnt == BLK_W'(BLINK_FRAMES - 1));
    assign w_nibble     = r_snap[{r_idx, 2'b00} +: BCD_W];

    bcd_to_seg7 u_dec (
        .i_bcd   (w_nibble),
        .o_seg_c (w_seg_dec)
    );

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        logic zero_above;
        w_lz_blank = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (r_snap[i*BCD_W +: BCD_W] == 4'd0);
            w_lz_blank[i] = zero_above;
        end
    end

    assign w_blank = (blank_lz && w_lz_blank[r_idx]) || (r_blink_phase && blink_en[r_idx]);

    always_comb begin
        w_out     = OUT_RESET;
        w_out.an  = ~(NUM_DIGITS'(1) << r_idx);
        if (!w_blank) begin
            w_out.seg = w_seg_dec;
            w_out.dp  = ~r_dp_snap[r_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div         <= '0;
            r_idx         <= '0;
            r_snap        <= '0;
            r_dp_snap     <= '0;
            r_blk_cnt     <= '0;
            r_blink_phase <= 1'b0;
            r_frame       <= 1'b0;
            r_out         <= OUT_RESET;
        end else begin
            r_div   <= w_tick ? '0 : r_div + 1'b1;
            r_frame <= w_wrap;
            r_out   <= w_out;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end
            // Frame boundary: snapshot inputs and advance the blink frame counter together
            if (w_wrap) begin
                r_snap    <= digits;
                r_dp_snap <= dp_mask;
                r_blk_cnt <= w_blink_wrap ? '0 : r_blk_cnt + 1'b1;
                if (w_blink_wrap) begin
                    r_blink_phase <= ~r_blink_phase;
                end
            end
        end
    end

    assign seg   = r_out.seg;
    assign dp    = r_out.dp;
    assign an    = r_out.an;
    assign frame = r_frame;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: a closed-form cycle model pushes expected
// outputs at each clock edge and the stimulus thread pops and compares at the falling edge.
module tb_bcd_scan_display;

    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FC = 4 * SD;
    localparam logic [12:0] RST_OUT = {1'b0, 4'hF, 1'b1, 7'h7F};

    logic        clk;
    logic        reset;
    logic [15:0] digits;
    logic        blank_lz;
    logic [3:0]  blink_en;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    int          n_checks;
    int          n_fail;
    string       tag;
    logic [12:0] sb_q[$];
    int          k;
    logic [15:0] m_snap;
    logic [3:0]  m_dpm;

    bcd_scan_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk      (clk),
        .reset    (reset),
        .digits   (digits),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .dp_mask  (dp_mask),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .frame    (frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] ref_seg(input logic [3:0] nib);
        case (nib)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Expected {frame, an, dp, seg} registered at edge kk+1, given kk edges since release.
    function automatic logic [12:0] model_out(input int kk, input logic [15:0] sn,
                                              input logic [3:0] dm, input logic blz,
                                              input logic [3:0] ben);
        int         idx;
        int         ph;
        logic       fr;
        logic       blank;
        logic [3:0] nib;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        idx   = (kk / SD) % 4;
        ph    = ((kk / FC) / BF) % 2;
        fr    = ((kk + 1) % FC) == 0;
        nib   = sn[4*idx +: 4];
        blank = (blz && idx != 0 && (sn >> (4 * idx)) == 16'h0) || (ph == 1 && ben[idx]);
        an_e  = 4'hF;
        an_e[idx] = 1'b0;
        seg_e = blank ? 7'h7F : ref_seg(nib);
        dp_e  = blank ? 1'b1 : ~dm[idx];
        return {fr, an_e, dp_e, seg_e};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            k      <= 0;
            m_snap <= '0;
            m_dpm  <= '0;
            sb_q.delete();
        end else begin
            sb_q.push_back(model_out(k, m_snap, m_dpm, blank_lz, blink_en));
            k <= k + 1;
            if ((k + 1) % FC == 0) begin
                m_snap <= digits;
                m_dpm  <= dp_mask;
            end
        end
    end

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, obs, exp_v, $time);
        end
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (!reset) check_eq("reset_out", {19'd0, frame, an, dp, seg}, {19'd0, RST_OUT});
            else if (sb_q.size() > 0) check_eq(tag, {19'd0, frame, an, dp, seg}, {19'd0, sb_q.pop_front()});
        end
    endtask

    task automatic wait_frame();
        int cnt;
        cnt = 0;
        while (frame !== 1'b1 && cnt < 3 * FC) begin
            step(1);
            cnt++;
        end
        if (frame !== 1'b1) check_eq("frame_timeout", 32'(frame), 32'd1);
    endtask

    initial begin
        int cnt;
        n_checks = 0;
        n_fail   = 0;
        tag      = "init";
        reset    = 1'b0;
        digits   = 16'h1234;
        blank_lz = 1'b0;
        blink_en = 4'h0;
        dp_mask  = 4'h0;

        step(3);
        reset = 1'b1;
        tag   = "scan_1234";
        cnt   = 0;
        while (frame !== 1'b1 && cnt < 40) begin
            step(1);
            cnt++;
        end
        check_eq("first_frame_cycle", 32'(cnt), 32'd16);
        step(2 * FC);

        tag = "lz_0007_on";
        digits = 16'h0007; blank_lz = 1'b1;
        step(2 * FC);
        tag = "lz_0007_off";
        blank_lz = 1'b0;
        step(2 * FC);

        tag = "lz_0000";
        digits = 16'h0000; blank_lz = 1'b1;
        step(2 * FC);
        tag = "dash_0A00";
        digits = 16'h0A00;
        step(2 * FC);

        tag = "tear_1111";
        digits = 16'h1111; blank_lz = 1'b0;
        wait_frame();
        wait_frame();
        step(5);
        digits = 16'h9999;
        step(3 * FC);

        tag = "blink_0005";
        digits = 16'h0005; blink_en = 4'b0001;
        step(6 * FC);

        tag = "dp_reset";
        blink_en = 4'h0; dp_mask = 4'b0100; digits = 16'h4321;
        step(FC + 6);
        #2 reset = 1'b0;
        #1 check_eq("reset_async", {19'd0, frame, an, dp, seg}, {19'd0, RST_OUT});
        step(3);
        reset = 1'b1;
        step(3 * FC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
